// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencing controller.
//
// Decides each cycle whether the PC advances, takes a branch offset, loads a
// jump target or holds. Arbitrates decode/execute redirects against load-use
// stalls and the program-halt marker. Generates IF/ID flush bubbles and a
// drain sequence that ends in a halted state.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   instruction     word currently fetched at PC (checked for HALT_WORD)
//   hazard_stall    load-use stall request from decode
//   br_req/br_offset  taken branch and its word offset
//   jmp_req/jmp_addr  resolved jump and its absolute target
//   stall           hold PC register (PC enable = ~stall)
//   branch_taken    select the offset adder input (1-cycle pulse)
//   jump_taken      select jmp_addr into PC (1-cycle pulse)
//   branch_offset   registered br_offset of the last accepted branch
//   new_addr        registered jmp_addr of the last accepted jump
//   flush_if_id     zero the IF/ID register this cycle
//   halted          program finished; held until rst
//
// Optional build macro FETCH_PERF_EN adds saturating counters:
//   perf_cycles     cycles spent in RUN, REDIRECT and DRAIN
//   perf_stalls     accepted hazard-stall cycles
//   perf_redirects  accepted jumps plus branches
//
// All outputs are registered: the combinational block computes the value each
// output takes after the next clock edge.

module fetch_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      FLUSH_CYCLES = 1,
  parameter int unsigned      DRAIN_CYCLES = 4,
  parameter logic [WIDTH-1:0] HALT_WORD    = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instruction,
  input  logic             hazard_stall,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_offset,
  input  logic             jmp_req,
  input  logic [WIDTH-1:0] jmp_addr,
  output logic             stall,
  output logic             branch_taken,
  output logic             jump_taken,
  output logic [WIDTH-1:0] branch_offset,
  output logic [WIDTH-1:0] new_addr,
  output logic             flush_if_id,
  output logic             halted
`ifdef FETCH_PERF_EN
  ,
  output logic [WIDTH-1:0] perf_cycles,
  output logic [WIDTH-1:0] perf_stalls,
  output logic [WIDTH-1:0] perf_redirects
`endif
);

  typedef enum logic [2:0] {
    BOOT     = 3'd0,
    RUN      = 3'd1,
    REDIRECT = 3'd2,
    DRAIN    = 3'd3,
    HALT     = 3'd4
  } state_t;

  // Flush counter holds the bubbles remaining after the one emitted on entry.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t           state, state_n;
  logic [2:0]       flush_cnt, flush_cnt_n;
  logic [3:0]       drain_cnt, drain_cnt_n;
  logic             stall_n, branch_taken_n, jump_taken_n, flush_n, halted_n;
  logic [WIDTH-1:0] branch_offset_n, new_addr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      flush_cnt     <= '0;
      drain_cnt     <= '0;
      stall         <= 1'b1;
      branch_taken  <= 1'b0;
      jump_taken    <= 1'b0;
      flush_if_id   <= 1'b0;
      halted        <= 1'b0;
      branch_offset <= '0;
      new_addr      <= '0;
    end else begin
      state         <= state_n;
      flush_cnt     <= flush_cnt_n;
      drain_cnt     <= drain_cnt_n;
      stall         <= stall_n;
      branch_taken  <= branch_taken_n;
      jump_taken    <= jump_taken_n;
      flush_if_id   <= flush_n;
      halted        <= halted_n;
      branch_offset <= branch_offset_n;
      new_addr      <= new_addr_n;
    end
  end

  always_comb begin
    state_n         = state;
    flush_cnt_n     = flush_cnt;
    drain_cnt_n     = drain_cnt;
    stall_n         = 1'b0;
    branch_taken_n  = 1'b0;
    jump_taken_n    = 1'b0;
    flush_n         = 1'b0;
    halted_n        = 1'b0;
    branch_offset_n = branch_offset;
    new_addr_n      = new_addr;

    unique case (state)
      BOOT: begin
        state_n = RUN;
      end

      RUN: begin
        if (jmp_req) begin
          jump_taken_n = 1'b1;
          new_addr_n   = jmp_addr;
          flush_n      = 1'b1;
          flush_cnt_n  = FLUSH_LOAD;
          state_n      = REDIRECT;
        end else if (br_req) begin
          branch_taken_n  = 1'b1;
          branch_offset_n = br_offset;
          flush_n         = 1'b1;
          flush_cnt_n     = FLUSH_LOAD;
          state_n         = REDIRECT;
        end else if (hazard_stall) begin
          stall_n = 1'b1;
        end else if (instruction == HALT_WORD) begin
          stall_n     = 1'b1;
          drain_cnt_n = DRAIN_LOAD;
          state_n     = DRAIN;
        end
      end

      // Wrong-path requests and halt markers are ignored here.
      REDIRECT: begin
        if (flush_cnt == '0) begin
          state_n = RUN;
        end else begin
          flush_n     = 1'b1;
          flush_cnt_n = flush_cnt - 3'd1;
        end
      end

      // Entering HALT on the decrement that reaches zero makes halted rise
      // exactly DRAIN_CYCLES cycles after stall went high.
      DRAIN: begin
        stall_n = 1'b1;
        if (drain_cnt <= 4'd1) begin
          drain_cnt_n = '0;
          halted_n    = 1'b1;
          state_n     = HALT;
        end else begin
          drain_cnt_n = drain_cnt - 4'd1;
        end
      end

      HALT: begin
        stall_n  = 1'b1;
        halted_n = 1'b1;
      end

      default: begin
        stall_n = 1'b1;
        state_n = BOOT;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic active, hazard_acc, redirect_acc;

  always_comb begin
    active       = (state == RUN) || (state == REDIRECT) || (state == DRAIN);
    hazard_acc   = (state == RUN) && hazard_stall && !jmp_req && !br_req;
    redirect_acc = (state == RUN) && (jmp_req || br_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles    <= '0;
      perf_stalls    <= '0;
      perf_redirects <= '0;
    end else begin
      if (active && (perf_cycles != '1))
        perf_cycles <= perf_cycles + 1'b1;
      if (hazard_acc && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 1'b1;
      if (redirect_acc && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (default parameters, perf counters disabled).
// Output vector order: {stall, branch_taken, jump_taken, flush_if_id, halted}.

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        hazard_stall;
  logic        br_req;
  logic [31:0] br_offset;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic        stall;
  logic        branch_taken;
  logic        jump_taken;
  logic [31:0] branch_offset;
  logic [31:0] new_addr;
  logic        flush_if_id;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl #(
    .WIDTH(32),
    .FLUSH_CYCLES(1),
    .DRAIN_CYCLES(4),
    .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .hazard_stall(hazard_stall),
    .br_req(br_req),
    .br_offset(br_offset),
    .jmp_req(jmp_req),
    .jmp_addr(jmp_addr),
    .stall(stall),
    .branch_taken(branch_taken),
    .jump_taken(jump_taken),
    .branch_offset(branch_offset),
    .new_addr(new_addr),
    .flush_if_id(flush_if_id),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {stall, branch_taken, jump_taken, flush_if_id, halted};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (stall,br,jmp,flush,halted)", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; instruction = 32'h0000_0013; hazard_stall = 1'b0;
    br_req = 1'b0; br_offset = '0; jmp_req = 1'b0; jmp_addr = '0;

    // Reset then run
    tick(); chk_ctl("reset1", 5'b10000);
    tick(); chk_ctl("reset2", 5'b10000);
    chk_word("reset_offset", branch_offset, 32'd0);
    chk_word("reset_addr", new_addr, 32'd0);
    rst = 1'b0;
    chk_ctl("boot", 5'b10000);
    tick(); chk_ctl("run1", 5'b00000);
    tick(); chk_ctl("run2", 5'b00000);

    // Branch, then wrong-path br_req during REDIRECT
    br_req = 1'b1; br_offset = 32'd3;
    tick(); chk_ctl("branch", 5'b01010);
    chk_word("branch_offset", branch_offset, 32'd3);
    br_offset = 32'd7;
    tick(); chk_ctl("redirect_ignore", 5'b00000);
    chk_word("offset_kept", branch_offset, 32'd3);
    br_req = 1'b0;
    tick(); chk_ctl("back_run", 5'b00000);

    // Jump/branch collision
    jmp_req = 1'b1; jmp_addr = 32'h40; br_req = 1'b1; br_offset = 32'd9;
    tick(); chk_ctl("collision", 5'b00110);
    chk_word("jump_addr", new_addr, 32'h40);
    chk_word("dropped_branch", branch_offset, 32'd3);
    jmp_req = 1'b0; br_req = 1'b0;
    tick(); chk_ctl("jmp_flush_end", 5'b00000);
    tick(); chk_ctl("jmp_run", 5'b00000);

    // Load-use, two cycles
    hazard_stall = 1'b1;
    tick(); chk_ctl("hazard1", 5'b10000);
    tick(); chk_ctl("hazard2", 5'b10000);
    hazard_stall = 1'b0;
    tick(); chk_ctl("hazard_release", 5'b00000);

    // Branch outranks hazard
    hazard_stall = 1'b1; br_req = 1'b1; br_offset = 32'd5;
    tick(); chk_ctl("br_over_hazard", 5'b01010);
    chk_word("br_over_hazard_off", branch_offset, 32'd5);
    hazard_stall = 1'b0; br_req = 1'b0;
    tick(); chk_ctl("bh_flush_end", 5'b00000);
    tick(); chk_ctl("bh_run", 5'b00000);

    // Halt with br_req pulses during DRAIN
    instruction = 32'hFFFF_FFFF;
    tick(); chk_ctl("drain0", 5'b10000);
    instruction = 32'h0000_0013; br_req = 1'b1; br_offset = 32'd11;
    tick(); chk_ctl("drain1", 5'b10000);
    br_req = 1'b0;
    tick(); chk_ctl("drain2", 5'b10000);
    br_req = 1'b1;
    tick(); chk_ctl("drain3", 5'b10000);
    br_req = 1'b0;
    tick(); chk_ctl("halted", 5'b10001);
    tick(); chk_ctl("halt_hold", 5'b10001);
    chk_word("drain_offset", branch_offset, 32'd5);

    // Reset out of HALT
    rst = 1'b1;
    tick(); chk_ctl("rst_halt", 5'b10000);
    rst = 1'b0;
    chk_ctl("boot2", 5'b10000);
    tick(); chk_ctl("run3", 5'b00000);

    // Reset mid-drain
    instruction = 32'hFFFF_FFFF;
    tick(); chk_ctl("mdrain0", 5'b10000);
    instruction = 32'h0000_0013;
    tick(); chk_ctl("mdrain1", 5'b10000);
    tick(); chk_ctl("mdrain2", 5'b10000);
    rst = 1'b1;
    tick(); chk_ctl("mdrain_rst1", 5'b10000);
    tick(); chk_ctl("mdrain_rst2", 5'b10000);
    rst = 1'b0;
    chk_ctl("boot3", 5'b10000);
    for (int i = 0; i < 6; i++) begin
      tick(); chk_ctl("resume_run", 5'b00000);
    end
    jmp_req = 1'b1; jmp_addr = 32'h80;
    tick(); chk_ctl("resume_jump", 5'b00110);
    chk_word("resume_addr", new_addr, 32'h80);
    jmp_req = 1'b0;
    tick(); chk_ctl("resume_flush_end", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
